wash_ctrl_gen2: RTL and testbench

Second-generation washing-machine control FSM with an integrated phase timer, a configurable wash/rinse repeat limit, pause/resume, and a load-detect timeout. It replaces the external 20-minute timer handshake with internal, parameterised phase durations. It sits between the front-panel and sensor inputs and the dispense and motor actuators, and exposes status for the panel display.

---
 rtl/wash_ctrl_gen2.sv | 158 +++++++++++++++
 tb/tb_wash_ctrl_gen2.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_ctrl_gen2.sv
// wash_ctrl_gen2: washing-machine sequencer with an internal phase timer,
// a wash/rinse repeat limit, pause/resume and a load-detect timeout.
`timescale 1ns/1ps
module wash_ctrl_gen2 #(
  parameter int TW           = 16,
  parameter int DISP_TICKS   = 4,
  parameter int WASH_TICKS   = 1200,
  parameter int RINSE_TICKS  = 1200,
  parameter int DRY_TICKS    = 1200,
  parameter int LOAD_TIMEOUT = 64,
  parameter int MAX_CYCLES   = 2
) (
  input  logic       CLOCK,
  input  logic       nRESET,
  input  logic       START,
  input  logic       PAUSE,
  input  logic       REGULAR,
  input  logic       LARGE,
  input  logic       DIRTY,
  input  logic       WET,
  output logic       REGULAR_DISP,
  output logic       LARGE_DISP,
  output logic       WASH,
  output logic       RINSE,
  output logic       DRY,
  output logic       BUSY,
  output logic       DONE_P,
  output logic       ERR_P,
  output logic [3:0] STATE,
  output logic [3:0] CYCLES
);

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_LOAD_DETECT = 4'd1,
    S_DISP_REG    = 4'd2,
    S_DISP_LRG    = 4'd3,
    S_WASH        = 4'd4,
    S_RINSE       = 4'd5,
    S_CHECK       = 4'd6,
    S_DRY         = 4'd7,
    S_DONE        = 4'd8,
    S_ERROR       = 4'd9
  } state_t;

  // Timer reload values are the phase length minus one so that the
  // clock on which the timer reads zero is the last clock of the phase.
  localparam logic [TW-1:0] LOAD_INIT  = TW'(LOAD_TIMEOUT - 1);
  localparam logic [TW-1:0] DISP_INIT  = TW'(DISP_TICKS - 1);
  localparam logic [TW-1:0] WASH_INIT  = TW'(WASH_TICKS - 1);
  localparam logic [TW-1:0] RINSE_INIT = TW'(RINSE_TICKS - 1);
  localparam logic [TW-1:0] DRY_INIT   = TW'(DRY_TICKS - 1);
  localparam logic [3:0]    MAX_PASSES = 4'(MAX_CYCLES);

  state_t        state;
  logic [TW-1:0] timer;
  logic [3:0]    cycles;
  logic [3:0]    cycles_next;
  logic          timer_zero;
  logic [TW-1:0] timer_dec;

  assign timer_zero  = (timer == '0);
  assign timer_dec   = timer_zero ? timer : timer - TW'(1);
  assign cycles_next = (cycles == 4'd15) ? 4'd15 : cycles + 4'd1;

  always_ff @(negedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      state  <= S_IDLE;
      timer  <= '0;
      cycles <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            state  <= S_LOAD_DETECT;
            timer  <= LOAD_INIT;
            cycles <= '0;
          end
        end
        S_LOAD_DETECT: begin
          if (REGULAR) begin
            state <= S_DISP_REG;
            timer <= DISP_INIT;
          end else if (LARGE) begin
            state <= S_DISP_LRG;
            timer <= DISP_INIT;
          end else if (timer_zero) begin
            state <= S_ERROR;
          end else begin
            timer <= timer_dec;
          end
        end
        S_DISP_REG, S_DISP_LRG: begin
          if (timer_zero) begin
            state <= S_WASH;
            timer <= WASH_INIT;
          end else begin
            timer <= timer_dec;
          end
        end
        // Timed phases hold both state and timer while paused.
        S_WASH: begin
          if (!PAUSE) begin
            if (timer_zero) begin
              state <= S_RINSE;
              timer <= RINSE_INIT;
            end else begin
              timer <= timer_dec;
            end
          end
        end
        S_RINSE: begin
          if (!PAUSE) begin
            if (timer_zero) begin
              state <= S_CHECK;
            end else begin
              timer <= timer_dec;
            end
          end
        end
        S_CHECK: begin
          cycles <= cycles_next;
          if (DIRTY && (cycles_next < MAX_PASSES)) begin
            state <= S_WASH;
            timer <= WASH_INIT;
          end else begin
            state <= S_DRY;
            timer <= DRY_INIT;
          end
        end
        S_DRY: begin
          if (!PAUSE) begin
            if (!WET || timer_zero) begin
              state <= S_DONE;
            end else begin
              timer <= timer_dec;
            end
          end
        end
        S_DONE, S_ERROR: state <= S_IDLE;
        default:         state <= S_IDLE;
      endcase
    end
  end

  // Moore decode; PAUSE is the only input allowed to reach the actuators.
  assign STATE        = state;
  assign CYCLES       = cycles;
  assign BUSY         = (state != S_IDLE);
  assign REGULAR_DISP = (state == S_DISP_REG);
  assign LARGE_DISP   = (state == S_DISP_LRG);
  assign WASH         = (state == S_WASH)  && !PAUSE;
  assign RINSE        = (state == S_RINSE) && !PAUSE;
  assign DRY          = (state == S_DRY)   && !PAUSE;
  assign DONE_P       = (state == S_DONE);
  assign ERR_P        = (state == S_ERROR);

endmodule

// File: tb/tb_wash_ctrl_gen2.sv
// Directed bench for wash_ctrl_gen2: short phase lengths, hand-derived
// per-clock state sequences and actuator counts for each scenario.
`timescale 1ns/1ps
module tb_wash_ctrl_gen2;

  logic       CLOCK;
  logic       nRESET;
  logic       START, PAUSE, REGULAR, LARGE, DIRTY, WET;
  logic       REGULAR_DISP, LARGE_DISP, WASH, RINSE, DRY, BUSY, DONE_P, ERR_P;
  logic [3:0] STATE, CYCLES;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations captured by run_job, one entry per clock of the job.
  logic [3:0] obs_state[$];
  logic       obs_busy[$];
  int n_rdisp, n_ldisp, n_wash, n_rinse, n_dry, n_done, n_err, n_act_paused;
  int done_at, err_at;
  int exp_st[$];

  wash_ctrl_gen2 #(
    .TW(16), .DISP_TICKS(2), .WASH_TICKS(5), .RINSE_TICKS(5), .DRY_TICKS(5),
    .LOAD_TIMEOUT(4), .MAX_CYCLES(3)
  ) dut (
    .CLOCK(CLOCK), .nRESET(nRESET), .START(START), .PAUSE(PAUSE),
    .REGULAR(REGULAR), .LARGE(LARGE), .DIRTY(DIRTY), .WET(WET),
    .REGULAR_DISP(REGULAR_DISP), .LARGE_DISP(LARGE_DISP), .WASH(WASH),
    .RINSE(RINSE), .DRY(DRY), .BUSY(BUSY), .DONE_P(DONE_P), .ERR_P(ERR_P),
    .STATE(STATE), .CYCLES(CYCLES)
  );

  // Registers move on falling edges; the bench samples on rising edges.
  initial begin
    CLOCK = 1'b1;
    forever #5 CLOCK = ~CLOCK;
  end

  task automatic push_run(input int code, input int n);
    repeat (n) exp_st.push_back(code);
  endtask

  // Entered and left just after a falling edge; one loop pass is one clock.
  task automatic run_job(input int ncyc, input logic reg_in, input logic lrg_in,
                         input logic dirty_in, input int wet_drop,
                         input logic [63:0] pause_mask, input logic start_hold);
    obs_state.delete();
    obs_busy.delete();
    n_rdisp = 0; n_ldisp = 0; n_wash = 0; n_rinse = 0; n_dry = 0;
    n_done = 0; n_err = 0; n_act_paused = 0; done_at = -1; err_at = -1;
    for (int c = 0; c < ncyc; c++) begin
      START   = (c == 0) || start_hold;
      REGULAR = reg_in;
      LARGE   = lrg_in;
      DIRTY   = dirty_in;
      WET     = (wet_drop < 0) || (c < wet_drop);
      PAUSE   = pause_mask[c];
      @(posedge CLOCK);
      obs_state.push_back(STATE);
      obs_busy.push_back(BUSY);
      if (REGULAR_DISP) n_rdisp++;
      if (LARGE_DISP) n_ldisp++;
      if (WASH) n_wash++;
      if (RINSE) n_rinse++;
      if (DRY) n_dry++;
      if (PAUSE && (WASH || RINSE || DRY)) n_act_paused++;
      if (DONE_P) begin n_done++; if (done_at < 0) done_at = c; end
      if (ERR_P) begin n_err++; if (err_at < 0) err_at = c; end
      @(negedge CLOCK);
      #1;
    end
    START = 1'b0; REGULAR = 1'b0; LARGE = 1'b0; DIRTY = 1'b0; WET = 1'b1; PAUSE = 1'b0;
  endtask

  task automatic build_regular_prefix();
    exp_st.delete();
    push_run(0, 1); push_run(1, 1); push_run(2, 2); push_run(4, 5); push_run(5, 5); push_run(6, 1);
  endtask

  task automatic test_reset();
    logic [19:0] outs;
    nRESET = 1'b0; START = 1'b0; PAUSE = 1'b0; REGULAR = 1'b0;
    LARGE = 1'b0; DIRTY = 1'b0; WET = 1'b1;
    #2;
    outs = {REGULAR_DISP, LARGE_DISP, WASH, RINSE, DRY, BUSY, DONE_P, ERR_P, STATE, CYCLES, 4'h0};
    n_tests++;
    if (outs !== 20'h0) begin
      n_fail++; $display("[TB] FAIL reset_outputs: got %h, expected 00000", outs);
    end
    @(negedge CLOCK);
    #1;
    nRESET = 1'b1;
    @(posedge CLOCK);
    n_tests++;
    if (STATE !== 4'd0 || BUSY !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_idle: state %0d busy %b, expected 0 0", STATE, BUSY);
    end
    @(negedge CLOCK);
    #1;
  endtask

  task automatic test_regular_job();
    build_regular_prefix(); push_run(7, 5); push_run(8, 1); push_run(0, 2);
    run_job(exp_st.size(), 1'b1, 1'b0, 1'b0, -1, 64'h0, 1'b0);
    for (int c = 0; c < exp_st.size(); c++) begin
      n_tests++;
      if (obs_state[c] !== 4'(exp_st[c]) || obs_busy[c] !== (exp_st[c] != 0)) begin
        n_fail++;
        $display("[TB] FAIL regular_seq c%0d: state %0d busy %b, expected %0d", c, obs_state[c], obs_busy[c], exp_st[c]);
      end
    end
    n_tests++;
    if ({n_rdisp, n_ldisp, n_wash, n_rinse, n_dry, n_done, n_err} !== {32'd2, 32'd0, 32'd5, 32'd5, 32'd5, 32'd1, 32'd0}) begin
      n_fail++;
      $display("[TB] FAIL regular_counts: rdisp %0d ldisp %0d wash %0d rinse %0d dry %0d done %0d err %0d, expected 2 0 5 5 5 1 0",
               n_rdisp, n_ldisp, n_wash, n_rinse, n_dry, n_done, n_err);
    end
    n_tests++;
    if (done_at !== 20 || CYCLES !== 4'd1 || BUSY !== 1'b0) begin
      n_fail++; $display("[TB] FAIL regular_end: done_at %0d cycles %0d busy %b, expected 20 1 0", done_at, CYCLES, BUSY);
    end
  endtask

  task automatic test_dirty_repeat();
    exp_st.delete();
    push_run(0, 1); push_run(1, 1); push_run(3, 2);
    repeat (3) begin push_run(4, 5); push_run(5, 5); push_run(6, 1); end
    push_run(7, 5); push_run(8, 1); push_run(0, 1);
    run_job(exp_st.size(), 1'b0, 1'b1, 1'b1, -1, 64'h0, 1'b0);
    for (int c = 0; c < exp_st.size(); c++) begin
      n_tests++;
      if (obs_state[c] !== 4'(exp_st[c]) || obs_busy[c] !== (exp_st[c] != 0)) begin
        n_fail++;
        $display("[TB] FAIL dirty_seq c%0d: state %0d busy %b, expected %0d", c, obs_state[c], obs_busy[c], exp_st[c]);
      end
    end
    n_tests++;
    if ({n_rdisp, n_ldisp, n_wash, n_rinse, n_dry} !== {32'd0, 32'd2, 32'd15, 32'd15, 32'd5}) begin
      n_fail++;
      $display("[TB] FAIL dirty_counts: rdisp %0d ldisp %0d wash %0d rinse %0d dry %0d, expected 0 2 15 15 5",
               n_rdisp, n_ldisp, n_wash, n_rinse, n_dry);
    end
    n_tests++;
    if (CYCLES !== 4'd3 || done_at !== 42) begin
      n_fail++; $display("[TB] FAIL dirty_end: cycles %0d done_at %0d, expected 3 42", CYCLES, done_at);
    end
  endtask

  task automatic test_pause();
    // Paused on clocks 11-13 mid-RINSE and on clock 16 where its timer is 0.
    exp_st.delete();
    push_run(0, 1); push_run(1, 1); push_run(2, 2); push_run(4, 5); push_run(5, 9);
    push_run(6, 1); push_run(7, 5); push_run(8, 1); push_run(0, 1);
    run_job(exp_st.size(), 1'b1, 1'b0, 1'b0, -1, 64'h13800, 1'b0);
    for (int c = 0; c < exp_st.size(); c++) begin
      n_tests++;
      if (obs_state[c] !== 4'(exp_st[c]) || obs_busy[c] !== (exp_st[c] != 0)) begin
        n_fail++;
        $display("[TB] FAIL pause_seq c%0d: state %0d busy %b, expected %0d", c, obs_state[c], obs_busy[c], exp_st[c]);
      end
    end
    n_tests++;
    if (n_rinse !== 5 || n_act_paused !== 0 || done_at !== 24) begin
      n_fail++;
      $display("[TB] FAIL pause_counts: rinse %0d paused_act %0d done_at %0d, expected 5 0 24", n_rinse, n_act_paused, done_at);
    end
  endtask

  task automatic test_early_dry();
    build_regular_prefix(); push_run(7, 2); push_run(8, 1); push_run(0, 1);
    run_job(exp_st.size(), 1'b1, 1'b0, 1'b0, 16, 64'h0, 1'b0);
    for (int c = 0; c < exp_st.size(); c++) begin
      n_tests++;
      if (obs_state[c] !== 4'(exp_st[c])) begin
        n_fail++; $display("[TB] FAIL early_dry_seq c%0d: state %0d, expected %0d", c, obs_state[c], exp_st[c]);
      end
    end
    n_tests++;
    if (n_dry !== 2 || done_at !== 17) begin
      n_fail++; $display("[TB] FAIL early_dry: dry %0d done_at %0d, expected 2 17", n_dry, done_at);
    end
    // WET already low on the first DRY clock.
    build_regular_prefix(); push_run(7, 1); push_run(8, 1); push_run(0, 1);
    run_job(exp_st.size(), 1'b1, 1'b0, 1'b0, 15, 64'h0, 1'b0);
    n_tests++;
    if (n_dry !== 1 || done_at !== 16 || obs_state[15] !== 4'd7) begin
      n_fail++; $display("[TB] FAIL dry_one_clock: dry %0d done_at %0d state15 %0d, expected 1 16 7", n_dry, done_at, obs_state[15]);
    end
  endtask

  task automatic test_timeout();
    exp_st.delete();
    push_run(0, 1); push_run(1, 4); push_run(9, 1); push_run(0, 1);
    run_job(exp_st.size(), 1'b0, 1'b0, 1'b0, -1, 64'h0, 1'b0);
    for (int c = 0; c < exp_st.size(); c++) begin
      n_tests++;
      if (obs_state[c] !== 4'(exp_st[c]) || obs_busy[c] !== (exp_st[c] != 0)) begin
        n_fail++;
        $display("[TB] FAIL timeout_seq c%0d: state %0d busy %b, expected %0d", c, obs_state[c], obs_busy[c], exp_st[c]);
      end
    end
    n_tests++;
    if (n_err !== 1 || err_at !== 5 || n_done !== 0) begin
      n_fail++; $display("[TB] FAIL timeout_err: err %0d err_at %0d done %0d, expected 1 5 0", n_err, err_at, n_done);
    end
  endtask

  task automatic test_sensor_priority();
    build_regular_prefix(); push_run(7, 5); push_run(8, 1); push_run(0, 1);
    run_job(exp_st.size(), 1'b1, 1'b1, 1'b0, -1, 64'h0, 1'b0);
    for (int c = 0; c < exp_st.size(); c++) begin
      n_tests++;
      if (obs_state[c] !== 4'(exp_st[c])) begin
        n_fail++; $display("[TB] FAIL priority_seq c%0d: state %0d, expected %0d", c, obs_state[c], exp_st[c]);
      end
    end
    n_tests++;
    if (n_rdisp !== 2 || n_ldisp !== 0) begin
      n_fail++; $display("[TB] FAIL priority_disp: rdisp %0d ldisp %0d, expected 2 0", n_rdisp, n_ldisp);
    end
  endtask

  task automatic test_reset_mid_wash();
    logic [19:0] outs;
    // Second wash pass of a dirty job: CYCLES is 1 at this point.
    run_job(17, 1'b0, 1'b1, 1'b1, -1, 64'h0, 1'b0);
    LARGE = 1'b1; DIRTY = 1'b1;
    @(posedge CLOCK);
    n_tests++;
    if (STATE !== 4'd4 || WASH !== 1'b1 || CYCLES !== 4'd1) begin
      n_fail++; $display("[TB] FAIL pre_reset: state %0d wash %b cycles %0d, expected 4 1 1", STATE, WASH, CYCLES);
    end
    #2;
    nRESET = 1'b0;
    #1;
    outs = {REGULAR_DISP, LARGE_DISP, WASH, RINSE, DRY, BUSY, DONE_P, ERR_P, STATE, CYCLES, 4'h0};
    n_tests++;
    if (outs !== 20'h0) begin
      n_fail++; $display("[TB] FAIL async_reset: got %h, expected 00000", outs);
    end
    @(negedge CLOCK);
    #1;
    LARGE = 1'b0; DIRTY = 1'b0;
    nRESET = 1'b1;
    @(posedge CLOCK);
    n_tests++;
    if (STATE !== 4'd0 || CYCLES !== 4'd0 || BUSY !== 1'b0) begin
      n_fail++; $display("[TB] FAIL post_reset: state %0d cycles %0d busy %b, expected 0 0 0", STATE, CYCLES, BUSY);
    end
    @(negedge CLOCK);
    #1;
  endtask

  task automatic test_back_to_back();
    build_regular_prefix(); push_run(7, 5); push_run(8, 1); push_run(0, 1);
    push_run(1, 1); push_run(2, 2);
    run_job(exp_st.size(), 1'b1, 1'b0, 1'b0, -1, 64'h0, 1'b1);
    for (int c = 0; c < exp_st.size(); c++) begin
      n_tests++;
      if (obs_state[c] !== 4'(exp_st[c])) begin
        n_fail++; $display("[TB] FAIL back_to_back_seq c%0d: state %0d, expected %0d", c, obs_state[c], exp_st[c]);
      end
    end
    n_tests++;
    if (n_done !== 1 || done_at !== 20) begin
      n_fail++; $display("[TB] FAIL back_to_back_done: done %0d done_at %0d, expected 1 20", n_done, done_at);
    end
  endtask

  initial begin
    test_reset();
    test_regular_job();
    test_dirty_repeat();
    test_pause();
    test_early_dry();
    test_timeout();
    test_sensor_priority();
    test_reset_mid_wash();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
